sdr_mem_bist: RTL

- Wishbone burst master placed directly upstream of the SDRAM controller top; its wb_* outputs connect to the controller's wb_* inputs.
- After SDRAM initialisation completes, it writes a programmable data pattern over an address range in bursts. It then reads the range back and checks every word.
- Reports pass/fail, an error count and details of the first mismatch. Used for bring-up and power-on memory test.

---
 rtl/sdr_mem_bist.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sdr_mem_bist.sv
// sdr_mem_bist: Wishbone burst-master memory self-test placed in front of the
// SDRAM controller. Once SDRAM init is done it writes a pattern over a range
// of words in bursts, reads the range back, and reports the outcome.
//
// Ports:
//   clk, reset_n          clock / async active-low reset
//   cfg_*                 test setup, latched on cfg_start while idle
//   sdr_init_done         SDRAM initialisation complete
//   wb_*_o / wb_*_i       Wishbone master towards the controller
//   bist_busy/done/pass   test status (pass valid while done)
//   bist_err_cnt          saturating mismatch count
//   bist_fail_addr/exp/act  details of the first mismatch
module sdr_mem_bist #(
    parameter int APP_AW = 26,
    parameter int dw     = 32,
    parameter int MAX_BL = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [APP_AW-1:0] cfg_base,
    input  logic [15:0]       cfg_words,
    input  logic [4:0]        cfg_bl,
    input  logic [1:0]        cfg_pat,
    input  logic [31:0]       cfg_seed,
    input  logic              sdr_init_done,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [3:0]        wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic [15:0]       bist_err_cnt,
    output logic [APP_AW-1:0] bist_fail_addr,
    output logic [dw-1:0]     bist_fail_exp,
    output logic [dw-1:0]     bist_fail_act
);
    localparam int BW = $clog2(MAX_BL + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, DONE
    } state_t;

    state_t            state;
    logic [APP_AW-1:0] base_q;
    logic [15:0]       words_q, words_left;
    logic [BW-1:0]     bl_q, beats_left;
    logic [1:0]        pat_q;
    logic [31:0]       seed_q, lfsr;

    logic [BW-1:0]     bl_clamped, burst_n;
    logic [15:0]       wl_src;
    logic [dw-1:0]     exp_data;
    logic              ack_beat;

    function automatic logic [31:0] lfsr_init(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    always_comb begin
        bl_clamped = BW'(cfg_bl);
        if (cfg_bl == 5'd0)
            bl_clamped = BW'(1);
        else if (32'(cfg_bl) > 32'(MAX_BL))
            bl_clamped = BW'(MAX_BL);
    end

    // The read pass restarts from the full word count, so the first read
    // burst is sized from words_q rather than the exhausted counter.
    assign wl_src  = (state == WR_GAP && words_left == 16'd0) ? words_q : words_left;
    assign burst_n = (wl_src < 16'(bl_q)) ? BW'(wl_src) : bl_q;

    always_comb begin
        case (pat_q)
            2'd0:    exp_data = dw'(wb_addr_o);
            2'd1:    exp_data = lfsr;
            2'd2:    exp_data = seed_q;
            default: exp_data = ~dw'(wb_addr_o);
        endcase
    end

    assign ack_beat = wb_stb_o && wb_ack_i && (state == WR_BURST || state == RD_BURST);
    assign wb_sel_o = wb_stb_o ? 4'hF : 4'h0;
    assign wb_dat_o = (wb_stb_o && wb_we_o) ? exp_data : '0;

    task automatic open_burst(input logic wr);
        wb_cyc_o   <= 1'b1;
        wb_stb_o   <= 1'b1;
        wb_we_o    <= wr;
        beats_left <= burst_n;
        wb_cti_o   <= (burst_n == BW'(1)) ? 3'b000 : 3'b010;
    endtask

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            base_q         <= '0;
            words_q        <= '0;
            words_left     <= '0;
            bl_q           <= '0;
            beats_left     <= '0;
            pat_q          <= '0;
            seed_q         <= '0;
            lfsr           <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_addr_o      <= '0;
            wb_cti_o       <= 3'b000;
            bist_busy      <= 1'b0;
            bist_done      <= 1'b0;
            bist_pass      <= 1'b0;
            bist_err_cnt   <= '0;
            bist_fail_addr <= '0;
            bist_fail_exp  <= '0;
            bist_fail_act  <= '0;
        end else begin
            case (state)
                IDLE: if (cfg_start) begin
                    base_q         <= {cfg_base[APP_AW-1:2], 2'b00};
                    wb_addr_o      <= {cfg_base[APP_AW-1:2], 2'b00};
                    words_q        <= cfg_words;
                    words_left     <= cfg_words;
                    bl_q           <= bl_clamped;
                    pat_q          <= cfg_pat;
                    seed_q         <= cfg_seed;
                    lfsr           <= lfsr_init(cfg_seed);
                    bist_busy      <= 1'b1;
                    bist_done      <= 1'b0;
                    bist_pass      <= 1'b0;
                    bist_err_cnt   <= '0;
                    bist_fail_addr <= '0;
                    bist_fail_exp  <= '0;
                    bist_fail_act  <= '0;
                    state          <= (cfg_words == 16'd0) ? DONE : WAIT_INIT;
                end
                WAIT_INIT: if (sdr_init_done) begin
                    open_burst(1'b1);
                    state <= WR_BURST;
                end
                WR_BURST, RD_BURST: if (ack_beat) begin
                    wb_addr_o  <= wb_addr_o + APP_AW'(4);
                    lfsr       <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
                    words_left <= words_left - 16'd1;
                    beats_left <= beats_left - BW'(1);
                    if (state == RD_BURST && wb_dat_i != exp_data) begin
                        if (bist_err_cnt == 16'd0) begin
                            bist_fail_addr <= wb_addr_o;
                            bist_fail_exp  <= exp_data;
                            bist_fail_act  <= wb_dat_i;
                        end
                        if (bist_err_cnt != 16'hFFFF)
                            bist_err_cnt <= bist_err_cnt + 16'd1;
                    end
                    if (beats_left == BW'(1)) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_cti_o <= 3'b000;
                        state    <= (state == WR_BURST) ? WR_GAP : RD_GAP;
                    end else if (beats_left == BW'(2)) begin
                        wb_cti_o <= 3'b111;
                    end
                end
                WR_GAP: begin
                    if (words_left != 16'd0) begin
                        open_burst(1'b1);
                        state <= WR_BURST;
                    end else begin
                        // Rewind address and generator so reads replay the sequence.
                        wb_addr_o  <= base_q;
                        lfsr       <= lfsr_init(seed_q);
                        words_left <= words_q;
                        open_burst(1'b0);
                        state      <= RD_BURST;
                    end
                end
                RD_GAP: begin
                    if (words_left != 16'd0) begin
                        open_burst(1'b0);
                        state <= RD_BURST;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bist_busy <= 1'b0;
                    bist_done <= 1'b1;
                    bist_pass <= (bist_err_cnt == 16'd0);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
